vga_sync_gen: RTL

//  Timing generator for the VGA path; the source of the pixel-coordinate/sync interface that pixel renderers consume.

---
 rtl/vga_sync_gen.sv | 119 +++++++++++
 1 files changed

// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing generator: pixel-rate divider, x/y counters, sync, blanking and strobes.
// Optional macro VGA_SYNC_PIPE_EN delays hsync/vsync/video_on by one pixel to match a registered rgb path.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIX_DIV  = 2,
  parameter int SYNC_POL = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       pix_tick,
  output logic       line_tick,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0] H_VIS_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] V_VIS_LAST = 10'(V_ACTIVE - 1);
  localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic       SYNC_ACT   = (SYNC_POL != 0);

  logic [DIV_W-1:0] div_reg, div_next;
  logic [9:0]       x_reg, x_next, y_reg, y_next;
  logic             pix_tick_reg;
  logic             hsync_reg, vsync_reg;
  logic             hs_act_next, vs_act_next;
  logic             video_comb;

  always_comb begin
    div_next = (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
    x_next   = x_reg;
    y_next   = y_reg;
    if (pix_tick_reg) begin
      if (x_reg == H_LAST) begin
        x_next = '0;
        y_next = (y_reg == V_LAST) ? 10'd0 : y_reg + 10'd1;
      end else begin
        x_next = x_reg + 10'd1;
      end
    end
    // Sync decode looks at next-state counters so sync flips on the same edge as x/y.
    hs_act_next = (x_next >= HS_START) && (x_next <= HS_END);
    vs_act_next = (y_next >= VS_START) && (y_next <= VS_END);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg      <= '0;
      pix_tick_reg <= 1'b0;
      x_reg        <= '0;
      y_reg        <= '0;
      hsync_reg    <= ~SYNC_ACT;
      vsync_reg    <= ~SYNC_ACT;
    end else begin
      div_reg      <= div_next;
      pix_tick_reg <= (div_next == DIV_LAST);
      x_reg        <= x_next;
      y_reg        <= y_next;
      hsync_reg    <= hs_act_next ? SYNC_ACT : ~SYNC_ACT;
      vsync_reg    <= vs_act_next ? SYNC_ACT : ~SYNC_ACT;
    end
  end

  assign video_comb = (x_reg < H_VIS) && (y_reg < V_VIS);

  assign x          = x_reg;
  assign y          = y_reg;
  assign pix_tick   = pix_tick_reg;
  // Strobes decode the pre-increment counters during the pix_tick cycle.
  assign line_tick  = pix_tick_reg && (x_reg == H_LAST);
  assign frame_tick = pix_tick_reg && (x_reg == H_VIS_LAST) && (y_reg == V_VIS_LAST);

`ifdef VGA_SYNC_PIPE_EN
  logic hsync_pipe_reg, vsync_pipe_reg, video_pipe_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_pipe_reg <= ~SYNC_ACT;
      vsync_pipe_reg <= ~SYNC_ACT;
      video_pipe_reg <= 1'b0;
    end else if (pix_tick_reg) begin
      hsync_pipe_reg <= hsync_reg;
      vsync_pipe_reg <= vsync_reg;
      video_pipe_reg <= video_comb;
    end
  end

  assign hsync    = hsync_pipe_reg;
  assign vsync    = vsync_pipe_reg;
  assign video_on = video_pipe_reg;
`else
  assign hsync    = hsync_reg;
  assign vsync    = vsync_reg;
  assign video_on = video_comb;
`endif

endmodule
